// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared opcode/phase encodings and widths for the accumulator CPU.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    // Opcodes that read an operand from memory into the accumulator path
    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_phase_ctr.sv
`default_nettype none
// ============================================================================
// Module   : cpu_phase_ctr
// Purpose  : Wrapping phase counter with advance enable, freeze and sync reset.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_phase_ctr
    import cpu_pkg::*;
#(
    parameter int NPHASE = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   freeze,
    output phase_t phase
);

    localparam int PW = $clog2(NPHASE);

    logic [PW-1:0] r_cnt;

    // NPHASE is a power of two, so natural overflow gives the wrap to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en && !freeze) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign phase = phase_t'(r_cnt);

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_controller
// Purpose  : Eight-phase sequencer producing memory and datapath strobes.
//            Optional sticky halt enabled by macro CPU_CTRL_HALT_STICKY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int NPHASE = 8,
    parameter int OPW    = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           sel,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           ld_ir,
    output logic           inc_pc,
    output logic           ld_pc,
    output logic           ld_ac,
    output logic           data_e,
    output logic           halt,
    output logic [2:0]     phase
);

    opcode_t w_op;
    phase_t  w_ph_reg;
    phase_t  w_ph;
    logic    w_halted;
    logic    w_alu;
    logic    w_sel, w_rd, w_wr, w_ldir, w_incpc, w_ldpc, w_ldac, w_de;

    assign w_op  = opcode_t'(opcode);
    assign w_alu = is_aluop(w_op);

    cpu_phase_ctr #(
        .NPHASE (NPHASE)
    ) u_phase_ctr (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .freeze (w_halted),
        .phase  (w_ph_reg)
    );

`ifdef CPU_CTRL_HALT_STICKY_EN
    logic r_halted;

    // Set on the edge that enters OP_ADDR, so the halted OP_ADDR never pulses inc_pc
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (en && (w_ph_reg == IDLE) && (w_op == HLT)) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halted = r_halted & ~rst;
`else
    assign w_halted = 1'b0;
`endif

    // Reset presents the INST_ADDR decode immediately so no stale strobes leak out
    assign w_ph = rst ? INST_ADDR : w_ph_reg;

    always_comb begin
        w_sel   = 1'b0;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_ldir  = 1'b0;
        w_incpc = 1'b0;
        w_ldpc  = 1'b0;
        w_ldac  = 1'b0;
        w_de    = 1'b0;
        case (w_ph)
            INST_ADDR: begin
                w_sel = 1'b1;
            end
            INST_FETCH: begin
                w_sel = 1'b1;
                w_rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                w_sel  = 1'b1;
                w_rd   = 1'b1;
                w_ldir = 1'b1;
            end
            OP_ADDR: begin
                w_incpc = 1'b1;
            end
            OP_FETCH: begin
                w_rd = w_alu;
            end
            ALU_OP: begin
                w_rd    = w_alu;
                w_incpc = (w_op == SKZ) && zero;
                w_ldpc  = (w_op == JMP);
                w_de    = (w_op == STO);
            end
            STORE: begin
                w_rd   = w_alu;
                w_ldac = w_alu;
                w_ldpc = (w_op == JMP);
                w_wr   = (w_op == STO);
                w_de   = (w_op == STO);
            end
            default: ;
        endcase
    end

    assign sel    = w_sel   & ~w_halted;
    assign mem_rd = w_rd    & ~w_halted;
    assign mem_wr = w_wr    & ~w_halted;
    assign ld_ir  = w_ldir  & ~w_halted;
    assign inc_pc = w_incpc & ~w_halted;
    assign ld_pc  = w_ldpc  & ~w_halted;
    assign ld_ac  = w_ldac  & ~w_halted;
    assign data_e = w_de    & ~w_halted;
    assign halt   = w_halted | ((w_ph == OP_ADDR) && (w_op == HLT));
    assign phase  = w_ph;

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_controller
// Purpose  : Directed table-driven bench for cpu_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;
    import cpu_pkg::*;

    // Strobe vector bit order: sel, mem_rd, mem_wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt
    localparam logic [8:0] c_P0   = 9'b100000000;
    localparam logic [8:0] c_P1   = 9'b110000000;
    localparam logic [8:0] c_P23  = 9'b110100000;
    localparam logic [8:0] c_P4   = 9'b000010000;
    localparam logic [8:0] c_RD   = 9'b010000000;
    localparam logic [8:0] c_WR   = 9'b001000000;
    localparam logic [8:0] c_INC  = 9'b000010000;
    localparam logic [8:0] c_LDPC = 9'b000001000;
    localparam logic [8:0] c_LDAC = 9'b000000100;
    localparam logic [8:0] c_DE   = 9'b000000010;
    localparam logic [8:0] c_H    = 9'b000000001;
    localparam logic [8:0] c_NONE = 9'b000000000;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] op;
        logic       zero;
        logic [2:0] ph;
        logic [8:0] exp;
    } row_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [2:0] opcode = ADD;
    logic       zero = 1'b0;
    logic       sel, mem_rd, mem_wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;
    logic [2:0] phase;
    logic [8:0] w_obs;

    int   n_cmp = 0;
    int   n_bad = 0;
    row_t tbl[$];

    always #5 clk = ~clk;

    cpu_controller #(
        .NPHASE (8),
        .OPW    (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .mem_rd (mem_rd),
        .mem_wr (mem_wr),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    assign w_obs = {sel, mem_rd, mem_wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt};

    function automatic void add(input logic r, input logic e, input logic [2:0] op,
                                input logic z, input logic [2:0] ph, input logic [8:0] ex);
        row_t x;
        x.rst = r; x.en = e; x.op = op; x.zero = z; x.ph = ph; x.exp = ex;
        tbl.push_back(x);
    endfunction

    task automatic check(input string name, input logic [2:0] ph, input logic [8:0] ex);
        n_cmp++;
        if (phase !== ph || w_obs !== ex) begin
            n_bad++;
            $display("FAIL %s: phase=%0d strobes=%b, required phase=%0d strobes=%b",
                     name, phase, w_obs, ph, ex);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Read and write strobes must never overlap
    always @(negedge clk) begin
        n_cmp++;
        if (mem_rd && mem_wr) begin
            n_bad++;
            $display("FAIL rd_wr_overlap: mem_rd=%b mem_wr=%b, required not both 1", mem_rd, mem_wr);
        end
    end

    initial begin
        // Reset row, then a full ADD cycle
        add(1, 1, ADD, 0, 0, c_P0);
        add(0, 1, ADD, 0, 0, c_P0);
        add(0, 1, ADD, 0, 1, c_P1);
        add(0, 1, ADD, 0, 2, c_P23);
        add(0, 1, ADD, 0, 3, c_P23);
        add(0, 1, ADD, 0, 4, c_P4);
        add(0, 1, ADD, 0, 5, c_RD);
        add(0, 1, ADD, 0, 6, c_RD);
        add(0, 1, ADD, 0, 7, c_RD | c_LDAC);
        // STO
        add(0, 1, STO, 0, 0, c_P0);
        add(0, 1, STO, 0, 1, c_P1);
        add(0, 1, STO, 0, 2, c_P23);
        add(0, 1, STO, 0, 3, c_P23);
        add(0, 1, STO, 0, 4, c_P4);
        add(0, 1, STO, 0, 5, c_NONE);
        add(0, 1, STO, 0, 6, c_DE);
        add(0, 1, STO, 0, 7, c_WR | c_DE);
        // SKZ with zero=1
        add(0, 1, SKZ, 1, 0, c_P0);
        add(0, 1, SKZ, 1, 1, c_P1);
        add(0, 1, SKZ, 1, 2, c_P23);
        add(0, 1, SKZ, 1, 3, c_P23);
        add(0, 1, SKZ, 1, 4, c_P4);
        add(0, 1, SKZ, 1, 5, c_NONE);
        add(0, 1, SKZ, 1, 6, c_INC);
        add(0, 1, SKZ, 1, 7, c_NONE);
        // SKZ with zero=0
        add(0, 1, SKZ, 0, 0, c_P0);
        add(0, 1, SKZ, 0, 1, c_P1);
        add(0, 1, SKZ, 0, 2, c_P23);
        add(0, 1, SKZ, 0, 3, c_P23);
        add(0, 1, SKZ, 0, 4, c_P4);
        add(0, 1, SKZ, 0, 5, c_NONE);
        add(0, 1, SKZ, 0, 6, c_NONE);
        add(0, 1, SKZ, 0, 7, c_NONE);
        // JMP
        add(0, 1, JMP, 0, 0, c_P0);
        add(0, 1, JMP, 0, 1, c_P1);
        add(0, 1, JMP, 0, 2, c_P23);
        add(0, 1, JMP, 0, 3, c_P23);
        add(0, 1, JMP, 0, 4, c_P4);
        add(0, 1, JMP, 0, 5, c_NONE);
        add(0, 1, JMP, 0, 6, c_LDPC);
        add(0, 1, JMP, 0, 7, c_LDPC);
        // Stall in phase 5, then reset from phase 6
        add(0, 1, ADD, 0, 0, c_P0);
        add(0, 1, ADD, 0, 1, c_P1);
        add(0, 1, ADD, 0, 2, c_P23);
        add(0, 1, ADD, 0, 3, c_P23);
        add(0, 1, ADD, 0, 4, c_P4);
        for (int k = 0; k < 5; k++) add(0, 0, ADD, 0, 5, c_RD);
        add(0, 1, ADD, 0, 5, c_RD);
        add(1, 1, ADD, 1, 0, c_P0);
        add(0, 1, ADD, 0, 0, c_P0);
        add(0, 1, ADD, 0, 1, c_P1);
        add(0, 1, ADD, 0, 2, c_P23);
        add(0, 1, ADD, 0, 3, c_P23);
        add(0, 1, ADD, 0, 4, c_P4);
        add(0, 1, ADD, 0, 5, c_RD);
        add(0, 1, ADD, 0, 6, c_RD);
        add(0, 1, ADD, 0, 7, c_RD | c_LDAC);

        for (int i = 0; i < tbl.size(); i++) begin
            rst    = tbl[i].rst;
            en     = tbl[i].en;
            opcode = tbl[i].op;
            zero   = tbl[i].zero;
            #1;
            check($sformatf("row%0d", i), tbl[i].ph, tbl[i].exp);
            step();
        end

        // Halt sequence
        rst = 1'b0; en = 1'b1; opcode = HLT; zero = 1'b0;
        #1; check("hlt_p0", 0, c_P0);  step();
        check("hlt_p1", 1, c_P1);      step();
        check("hlt_p2", 2, c_P23);     step();
        check("hlt_p3", 3, c_P23);     step();
`ifdef CPU_CTRL_HALT_STICKY_EN
        for (int k = 0; k < 22; k++) begin
            check($sformatf("hlt_hold%0d", k), 4, c_H);
            step();
        end
        rst = 1'b1;
        #1; check("hlt_rst", 0, c_P0); step();
        rst = 1'b0; opcode = ADD;
        #1; check("hlt_resume0", 0, c_P0); step();
        check("hlt_resume1", 1, c_P1);     step();
`else
        check("hlt_p4", 4, c_INC | c_H); step();
        check("hlt_p5", 5, c_NONE);      step();
        check("hlt_p6", 6, c_NONE);      step();
        check("hlt_p7", 7, c_NONE);      step();
        check("hlt_wrap0", 0, c_P0);     step();
        check("hlt_wrap1", 1, c_P1);     step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Eight-phase sequencer for the 8-bit accumulator CPU; sits directly upstream of the 32x8 data/instruction memory.
- Generates the memory read/write strobes, the address-source select, and the datapath load/increment strobes, from the decoded opcode and the ALU zero flag.
- `mem_rd`/`mem_wr` connect directly to the memory's read-enable and write-enable.
- `sel` steers the memory address mux between the PC (fetch) and the IR operand field (execute).

Parameters:
- NPHASE, 8, number of sequencer phases; fixed at 8, must be a power of two.
- OPW, 3, opcode width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  phase-advance enable; low = stall, phase and all strobes hold.
- opcode  input  OPW  instruction opcode from the IR, stable from phase IDLE onward.
- zero  input  1  accumulator-zero flag.
- sel  output  1  1 = memory address from PC, 0 = from IR operand.
- mem_rd  output  1  memory read enable.
- mem_wr  output  1  memory write enable.
- ld_ir  output  1  instruction-register load.
- inc_pc  output  1  PC increment.
- ld_pc  output  1  PC load (jump).
- ld_ac  output  1  accumulator load.
- data_e  output  1  accumulator-to-data-bus drive enable.
- halt  output  1  CPU halted.
- phase  output  3  current phase, for debug.

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Phase register: 3 bits; reset to INST_ADDR(0).
  - Advances by 1 on a clk edge when `en`=1 and not halted.
  - Wraps from STORE(7) to INST_ADDR(0).
- Strobes are combinational decodes of the registered phase and the current opcode/zero. They change only after a phase edge or an opcode/zero change.
- Phase table; unlisted strobes are 0:
  - 0 INST_ADDR: sel=1.
  - 1 INST_FETCH: sel=1, mem_rd=1.
  - 2 INST_LOAD: sel=1, mem_rd=1, ld_ir=1.
  - 3 IDLE: sel=1, mem_rd=1, ld_ir=1.
  - 4 OP_ADDR: inc_pc=1; halt asserts if opcode=HLT.
  - 5 OP_FETCH: mem_rd=ALUOP.
  - 6 ALU_OP: mem_rd=ALUOP, inc_pc=(SKZ & zero), ld_pc=JMP, data_e=STO.
  - 7 STORE: mem_rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, mem_wr=STO, data_e=STO.
- `mem_rd` and `mem_wr` are never both 1 in the same cycle.
- `mem_wr` is asserted only in STORE, so `data_e` is already high one phase earlier to give setup time.
- Stall: with `en`=0 the phase holds indefinitely. Strobes stay at the decode of the held phase; a write strobe held across a stall rewrites the same location, which is harmless.
- Reset:
  - During reset and on the first cycle after it: phase=0, sel=1, halt=0, all other outputs 0.
  - Reset has priority over `en` and over the halted state.
  - Reset in mid-sequence returns to INST_ADDR on the next edge, with no trailing strobes.
- Halt: see Optional Feature.

Optional Feature:
- Macro: CPU_CTRL_HALT_STICKY_EN.
- Defined:
  - Reaching OP_ADDR with opcode=HLT sets an internal halted flag on that edge.
  - The phase freezes at OP_ADDR and `halt` stays 1 until `rst`.
  - While halted, all strobes other than `halt` are forced to 0; in particular `inc_pc` is not repeated.
- Undefined:
  - `halt` is a pure decode, high only while in OP_ADDR with HLT.
  - Sequencing continues and the external PC logic is responsible for stopping.

Decomposition:
- Package cpu_pkg:
  - opcode_t: 3-bit enum with the values above.
  - phase_t: 3-bit enum INST_ADDR..STORE.
  - Shared constants DATA_W=8 and ADDR_W=5, used by memory, ALU and controller.
- Sub-module cpu_phase_ctr: 3-bit wrapping counter with en, freeze and sync reset, exposing phase_t.
- The controller instantiates cpu_phase_ctr and holds the strobe decode plus the halted flag.

Test Plan:
- Reset, then 8 cycles with en=1 and opcode=ADD: phase steps 0..7 then back to 0; mem_rd is high in phases 1,2,3,5,6,7; ld_ac is high only in phase 7; mem_wr never asserts.
- opcode=STO: data_e=1 in phases 6 and 7, mem_wr=1 only in phase 7, mem_rd=0 in phases 5..7.
- opcode=SKZ with zero=1: inc_pc pulses in phases 4 and 6. Repeat with zero=0: inc_pc pulses in phase 4 only.
- opcode=JMP: ld_pc=1 in phases 6 and 7, and inc_pc=1 in phase 4.
- en=0 held 5 cycles in phase 5, then rst asserted in phase 6:
  - During the stall, phase stays at 5 and the outputs are unchanged.
  - On the edge after rst, phase=0, sel=1 and all other strobes are 0.
- With CPU_CTRL_HALT_STICKY_EN and opcode=HLT:
  - halt rises in phase 4 and the phase holds at 4 for at least 20 cycles with inc_pc=0.
  - rst clears halt, and sequencing resumes from phase 0.
